bf_result_checker: RTL and testbench
====================================

Name: bf_result_checker

Overview:
- Downstream consumer of the bellmanford core.
- After the core finishes, the block sweeps the Output Memory distance table and compares each 16-bit word against a golden reference memory. It also compares the NegCycle flag against the expected flag.
- It reports pass/fail, the mismatch count and the first failing address. Regression benches use it instead of offline diffs of dumped .mem files.

Parameters:
- ADDR_W, 13, address width of the Output and Golden memories.
- DATA_W, 16, distance word width.
- NUM_WORDS, 8192, number of words swept, starting at address 0. Legal range is 1..2^ADDR_W.
- CNT_W, 14, mismatch counter width. It must hold NUM_WORDS.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a sweep. Ignored unless the FSM is in IDLE or DONE.
- OMAR  out  ADDR_W  Output Memory read address.
- OMDR  in  DATA_W  Output Memory read data; combinational read of OMAR.
- GAR  out  ADDR_W  Golden memory read address; always equal to OMAR.
- GDR  in  DATA_W  Golden memory read data; combinational read.
- NegCycle  in  1  negative-cycle flag from the core, sampled on start.
- ExpNegCycle  in  1  expected negative-cycle flag, sampled on start.
- busy  out  1  high from the cycle after start until done rises.
- done  out  1  high in DONE; held until the next start or reset.
- pass  out  1  valid while done=1: mismatch_count==0 and flag_ok.
- flag_ok  out  1  NegCycle==ExpNegCycle as sampled on start.
- mismatch_count  out  CNT_W  number of differing words; saturates at all-ones.
- first_mismatch_addr  out  ADDR_W  lowest address that differed; 0 if none.
- first_mismatch_found  out  1  high once any mismatch has been recorded.

Behaviour:
- Reset (asynchronous assert, synchronous release) takes the FSM to IDLE. All outputs are 0, including OMAR/GAR, busy, done, pass, flag_ok, the counters and the first-mismatch fields.
- FSM states: IDLE, SWEEP, FINISH, DONE.
- IDLE or DONE, start=1:
  - clear mismatch_count, first_mismatch_found, first_mismatch_addr and done;
  - OMAR=0;
  - latch flag_ok = (NegCycle==ExpNegCycle);
  - go to SWEEP; busy=1 next cycle.
- SWEEP, every cycle:
  - compare OMDR with GDR at the current OMAR (reads are combinational, so data belongs to the current address);
  - on inequality, increment mismatch_count, saturating at 2^CNT_W-1;
  - if first_mismatch_found=0, set it and capture first_mismatch_addr=OMAR;
  - if OMAR==NUM_WORDS-1, go to FINISH and hold OMAR; otherwise OMAR+1.
- FINISH: exactly one cycle. busy=0, done=1, pass = flag_ok & (mismatch_count==0). Go to DONE.
- DONE: all results held stable until the next start or reset.
- Latency: done rises NUM_WORDS+2 cycles after the start edge (1 start cycle, NUM_WORDS compare cycles, 1 finish cycle).
- start during SWEEP or FINISH is ignored; no restart and no effect on results.
- Address never wraps. NUM_WORDS=2^ADDR_W terminates on the all-ones address; the comparison uses ADDR_W bits only.
- NUM_WORDS=1: single SWEEP cycle at address 0, then FINISH.
- Reset asserted mid-sweep: the FSM returns to IDLE immediately and results are cleared. A new start is required afterwards.
- X on OMDR/GDR counts as a mismatch (case-inequality semantics in the compare). This lets unwritten Output Memory words fail.
- The block never writes either memory. It is only used after the bellmanford core has stopped writing Output Memory; bench arbitration of the shared read port is outside this block.

Decomposition:
- Shared package bf_pkg holds:
  - ADDR_W, DATA_W defaults;
  - the state enum {IDLE, SWEEP, FINISH, DONE} as a 2-bit typedef bf_chk_state_t;
  - INF_DIST=16'h7FFF, for the benches' golden generation.
- One sub-module is natural: bf_sat_counter (CNT_W-bit, synchronous clear, saturating increment), reused by later profiling blocks.
- Everything else stays in bf_result_checker.

Test Plan:
- Identical memories, NUM_WORDS=16, NegCycle=ExpNegCycle=0, start pulse -> done at cycle 18 after start, pass=1, mismatch_count=0, first_mismatch_found=0.
- Golden differs at addresses 5 and 9 (e.g. 16'h0003 vs 16'h0004) -> mismatch_count=2, first_mismatch_addr=5, first_mismatch_found=1, pass=0.
- Memories equal, NegCycle=1, ExpNegCycle=0 -> flag_ok=0, pass=0, mismatch_count=0.
- CNT_W=2, NUM_WORDS=8, all words differ -> mismatch_count saturates at 3, first_mismatch_addr=0, pass=0.
- reset driven low at sweep address 7, released, new start -> immediate return to IDLE with all outputs 0; the second sweep's results are correct and independent of the first.
- start re-pulsed during SWEEP, and NUM_WORDS=1 -> no restart (done timing unchanged); single-word sweep gives done 3 cycles after start.

Source files
------------

// File: rtl/bf_pkg.sv
// Shared definitions for the bellmanford result-checking blocks.
package bf_pkg;

  // Default memory geometry of the bellmanford Output Memory.
  localparam int BF_ADDR_W    = 13;
  localparam int BF_DATA_W    = 16;
  localparam int BF_CNT_W     = 14;
  localparam int BF_NUM_WORDS = 8192;

  // Distance value used for unreachable nodes when benches build golden tables.
  localparam logic [15:0] INF_DIST = 16'h7FFF;

  // Checker sequencing states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SWEEP  = 2'd1,
    FINISH = 2'd2,
    DONE   = 2'd3
  } bf_chk_state_t;

endpackage

// File: rtl/bf_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module bf_sat_counter #(
  parameter int CNT_W = 14
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Clear wins over increment; increment stops once the counter is full.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/bf_result_checker.sv
// Sweeps the Output Memory against a golden memory after the bellmanford core
// stops, and reports mismatch count, first failing address and flag agreement.
//
//   state  | meaning
//   IDLE   | waiting for start after reset
//   SWEEP  | one word compared per cycle, OMAR walks 0..NUM_WORDS-1
//   FINISH | single cycle that publishes done/pass from settled results
//   DONE   | results held until the next start or reset
module bf_result_checker
  import bf_pkg::*;
#(
  parameter int ADDR_W    = BF_ADDR_W,
  parameter int DATA_W    = BF_DATA_W,
  parameter int NUM_WORDS = BF_NUM_WORDS,
  parameter int CNT_W     = BF_CNT_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] OMAR,
  input  logic [DATA_W-1:0] OMDR,
  output logic [ADDR_W-1:0] GAR,
  input  logic [DATA_W-1:0] GDR,
  input  logic              NegCycle,
  input  logic              ExpNegCycle,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              flag_ok,
  output logic [CNT_W-1:0]  mismatch_count,
  output logic [ADDR_W-1:0] first_mismatch_addr,
  output logic              first_mismatch_found
);

  // Terminal address; truncation to ADDR_W makes NUM_WORDS=2^ADDR_W end on all-ones.
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

  bf_chk_state_t state;
  bf_chk_state_t state_next;
  logic          start_accept;
  logic          word_mismatch;
  logic          at_last;
  logic          count_inc;

  // Case inequality so that undefined memory words are reported as failures.
  assign word_mismatch = (OMDR !== GDR);
  assign at_last       = (OMAR == LAST_ADDR);
  assign count_inc     = (state == SWEEP) && word_mismatch;
  assign GAR           = OMAR;

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode; start is only honoured from IDLE or DONE.
  always_comb begin
    state_next   = state;
    start_accept = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          start_accept = 1'b1;
          state_next   = SWEEP;
        end
      end
      SWEEP: begin
        if (at_last) begin
          state_next = FINISH;
        end
      end
      FINISH: begin
        state_next = DONE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Address walk, flag latch, first-mismatch capture and result publication.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      OMAR                 <= '0;
      busy                 <= 1'b0;
      done                 <= 1'b0;
      pass                 <= 1'b0;
      flag_ok              <= 1'b0;
      first_mismatch_addr  <= '0;
      first_mismatch_found <= 1'b0;
    end else begin
      if (start_accept) begin
        OMAR                 <= '0;
        busy                 <= 1'b1;
        done                 <= 1'b0;
        pass                 <= 1'b0;
        flag_ok              <= (NegCycle == ExpNegCycle);
        first_mismatch_addr  <= '0;
        first_mismatch_found <= 1'b0;
      end else if (state == SWEEP) begin
        if (word_mismatch && !first_mismatch_found) begin
          first_mismatch_found <= 1'b1;
          first_mismatch_addr  <= OMAR;
        end
        if (!at_last) begin
          OMAR <= OMAR + ADDR_W'(1);
        end
      end else if (state == FINISH) begin
        // The last compare has landed in the counter by now, so pass is final.
        busy <= 1'b0;
        done <= 1'b1;
        pass <= flag_ok && (mismatch_count == '0);
      end
    end
  end

  bf_sat_counter #(
    .CNT_W(CNT_W)
  ) u_mismatch_cnt (
    .clock(clock),
    .reset(reset),
    .clear(start_accept),
    .inc  (count_inc),
    .count(mismatch_count)
  );

endmodule

// File: tb/tb_bf_result_checker.sv
// Directed bench for bf_result_checker: three instances cover a 16-word sweep,
// a saturating 2-bit counter over a full 3-bit address space, and a 1-word sweep.
module tb_bf_result_checker;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  int   tests_run = 0;
  int   tests_failed = 0;

  always #5 clock = ~clock;

  // Instance A: 16 words, default widths
  logic        start_a = 1'b0, neg_a = 1'b0, exp_a = 1'b0;
  logic [12:0] omar_a, gar_a, fma_a;
  logic [15:0] omdr_a, gdr_a;
  logic        busy_a, done_a, pass_a, flag_ok_a, fmf_a;
  logic [13:0] cnt_a;
  logic [15:0] om_a [16];
  logic [15:0] gm_a [16];
  assign omdr_a = om_a[omar_a[3:0]];
  assign gdr_a  = gm_a[gar_a[3:0]];

  bf_result_checker #(.ADDR_W(13), .DATA_W(16), .NUM_WORDS(16), .CNT_W(14)) dut_a (
    .clock(clock), .reset(rst_n), .start(start_a),
    .OMAR(omar_a), .OMDR(omdr_a), .GAR(gar_a), .GDR(gdr_a),
    .NegCycle(neg_a), .ExpNegCycle(exp_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .flag_ok(flag_ok_a),
    .mismatch_count(cnt_a), .first_mismatch_addr(fma_a), .first_mismatch_found(fmf_a));

  // Instance B: 3-bit address, 8 words (2^ADDR_W), 2-bit counter
  logic        start_b = 1'b0, neg_b = 1'b0, exp_b = 1'b0;
  logic [2:0]  omar_b, gar_b, fma_b;
  logic [15:0] omdr_b, gdr_b;
  logic        busy_b, done_b, pass_b, flag_ok_b, fmf_b;
  logic [1:0]  cnt_b;
  logic [15:0] om_b [8];
  logic [15:0] gm_b [8];
  assign omdr_b = om_b[omar_b];
  assign gdr_b  = gm_b[gar_b];

  bf_result_checker #(.ADDR_W(3), .DATA_W(16), .NUM_WORDS(8), .CNT_W(2)) dut_b (
    .clock(clock), .reset(rst_n), .start(start_b),
    .OMAR(omar_b), .OMDR(omdr_b), .GAR(gar_b), .GDR(gdr_b),
    .NegCycle(neg_b), .ExpNegCycle(exp_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .flag_ok(flag_ok_b),
    .mismatch_count(cnt_b), .first_mismatch_addr(fma_b), .first_mismatch_found(fmf_b));

  // Instance C: single word
  logic        start_c = 1'b0, neg_c = 1'b0, exp_c = 1'b0;
  logic [12:0] omar_c, gar_c, fma_c;
  logic [15:0] omdr_c, gdr_c;
  logic        busy_c, done_c, pass_c, flag_ok_c, fmf_c;
  logic [13:0] cnt_c;
  logic [15:0] om_c, gm_c;
  assign omdr_c = (omar_c == 13'd0) ? om_c : 16'hDEAD;
  assign gdr_c  = (gar_c == 13'd0) ? gm_c : 16'hBEEF;

  bf_result_checker #(.ADDR_W(13), .DATA_W(16), .NUM_WORDS(1), .CNT_W(14)) dut_c (
    .clock(clock), .reset(rst_n), .start(start_c),
    .OMAR(omar_c), .OMDR(omdr_c), .GAR(gar_c), .GDR(gdr_c),
    .NegCycle(neg_c), .ExpNegCycle(exp_c),
    .busy(busy_c), .done(done_c), .pass(pass_c), .flag_ok(flag_ok_c),
    .mismatch_count(cnt_c), .first_mismatch_addr(fma_c), .first_mismatch_found(fmf_c));

  task automatic fill_a_equal();
    for (int i = 0; i < 16; i++) begin
      om_a[i] = 16'(i * 3);
      gm_a[i] = 16'(i * 3);
    end
  endtask

  task automatic test_reset();
    @(negedge clock);
    tests_run++;
    if ({omar_a, busy_a, done_a, pass_a, flag_ok_a, cnt_a, fma_a, fmf_a} !== 46'd0) begin
      tests_failed++;
      $display("FAIL reset_a: got omar=%0d busy=%b done=%b pass=%b flag_ok=%b cnt=%0d fma=%0d fmf=%b, expected all 0",
               omar_a, busy_a, done_a, pass_a, flag_ok_a, cnt_a, fma_a, fmf_a);
    end
    tests_run++;
    if ({omar_b, busy_b, done_b, pass_b, flag_ok_b, cnt_b, fma_b, fmf_b, gar_c, done_c} !== 28'd0) begin
      tests_failed++;
      $display("FAIL reset_bc: got omar_b=%0d done_b=%b cnt_b=%0d gar_c=%0d done_c=%b, expected all 0",
               omar_b, done_b, cnt_b, gar_c, done_c);
    end
    rst_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_identical();
    fill_a_equal();
    neg_a = 1'b0; exp_a = 1'b0;
    start_a = 1'b1;
    @(negedge clock);  // 1 cycle after start
    start_a = 1'b0;
    tests_run++;
    if (busy_a !== 1'b1 || done_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL ident_busy: got busy=%b done=%b, expected busy=1 done=0", busy_a, done_a);
    end
    repeat (16) @(negedge clock);  // 17
    tests_run++;
    if (done_a !== 1'b0 || busy_a !== 1'b1) begin
      tests_failed++;
      $display("FAIL ident_early: at cycle 17 got done=%b busy=%b, expected done=0 busy=1", done_a, busy_a);
    end
    @(negedge clock);  // 18
    tests_run++;
    if ({done_a, busy_a, pass_a, flag_ok_a, fmf_a} !== 5'b10110 || cnt_a !== 14'd0 || fma_a !== 13'd0) begin
      tests_failed++;
      $display("FAIL ident_result: got done=%b busy=%b pass=%b flag_ok=%b fmf=%b cnt=%0d fma=%0d, expected 1 0 1 1 0 0 0",
               done_a, busy_a, pass_a, flag_ok_a, fmf_a, cnt_a, fma_a);
    end
    tests_run++;
    if (omar_a !== 13'd15 || gar_a !== 13'd15) begin
      tests_failed++;
      $display("FAIL ident_omar_hold: got omar=%0d gar=%0d, expected 15", omar_a, gar_a);
    end
    repeat (3) @(negedge clock);
    tests_run++;
    if (done_a !== 1'b1 || pass_a !== 1'b1 || omar_a !== 13'd15) begin
      tests_failed++;
      $display("FAIL ident_held: got done=%b pass=%b omar=%0d, expected 1 1 15", done_a, pass_a, omar_a);
    end
  endtask

  task automatic test_two_mismatches();
    fill_a_equal();
    om_a[5] = 16'h0003; gm_a[5] = 16'h0004;
    om_a[9] = 16'h0003; gm_a[9] = 16'h0004;
    start_a = 1'b1;
    @(negedge clock);
    start_a = 1'b0;
    tests_run++;
    if (done_a !== 1'b0 || pass_a !== 1'b0 || cnt_a !== 14'd0 || fmf_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL mm_clear: got done=%b pass=%b cnt=%0d fmf=%b, expected all 0 after restart",
               done_a, pass_a, cnt_a, fmf_a);
    end
    repeat (17) @(negedge clock);
    tests_run++;
    if (done_a !== 1'b1 || cnt_a !== 14'd2 || fma_a !== 13'd5 || fmf_a !== 1'b1 || pass_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL mm_result: got done=%b cnt=%0d fma=%0d fmf=%b pass=%b, expected 1 2 5 1 0",
               done_a, cnt_a, fma_a, fmf_a, pass_a);
    end
  endtask

  task automatic test_flag();
    fill_a_equal();
    neg_a = 1'b1; exp_a = 1'b0;
    start_a = 1'b1;
    @(negedge clock);
    start_a = 1'b0;
    neg_a = 1'b0;  // sampled only at start
    tests_run++;
    if (flag_ok_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL flag_latch: got flag_ok=%b, expected 0", flag_ok_a);
    end
    repeat (17) @(negedge clock);
    tests_run++;
    if (done_a !== 1'b1 || pass_a !== 1'b0 || cnt_a !== 14'd0 || flag_ok_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL flag_result: got done=%b pass=%b cnt=%0d flag_ok=%b, expected 1 0 0 0",
               done_a, pass_a, cnt_a, flag_ok_a);
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 8; i++) begin
      om_b[i] = 16'(i);
      gm_b[i] = 16'(i) + 16'h0100;
    end
    start_b = 1'b1;
    @(negedge clock);
    start_b = 1'b0;
    repeat (8) @(negedge clock);  // 9
    tests_run++;
    if (done_b !== 1'b0) begin
      tests_failed++;
      $display("FAIL sat_early: got done=%b at cycle 9, expected 0", done_b);
    end
    @(negedge clock);  // 10
    tests_run++;
    if (done_b !== 1'b1 || cnt_b !== 2'd3 || fma_b !== 3'd0 || fmf_b !== 1'b1 || pass_b !== 1'b0) begin
      tests_failed++;
      $display("FAIL sat_result: got done=%b cnt=%0d fma=%0d fmf=%b pass=%b, expected 1 3 0 1 0",
               done_b, cnt_b, fma_b, fmf_b, pass_b);
    end
    tests_run++;
    if (omar_b !== 3'd7 || flag_ok_b !== 1'b1) begin
      tests_failed++;
      $display("FAIL sat_omar: got omar=%0d flag_ok=%b, expected 7 1", omar_b, flag_ok_b);
    end
  endtask

  task automatic test_reset_mid();
    fill_a_equal();
    gm_a[2] = 16'hFFFF;
    start_a = 1'b1;
    @(negedge clock);
    start_a = 1'b0;
    repeat (7) @(negedge clock);  // 8: OMAR should be 7
    tests_run++;
    if (omar_a !== 13'd7 || fmf_a !== 1'b1 || fma_a !== 13'd2) begin
      tests_failed++;
      $display("FAIL rmid_pre: got omar=%0d fmf=%b fma=%0d, expected 7 1 2", omar_a, fmf_a, fma_a);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({omar_a, busy_a, done_a, pass_a, flag_ok_a, cnt_a, fma_a, fmf_a} !== 46'd0) begin
      tests_failed++;
      $display("FAIL rmid_clear: got omar=%0d busy=%b done=%b flag_ok=%b cnt=%0d fma=%0d fmf=%b, expected all 0",
               omar_a, busy_a, done_a, flag_ok_a, cnt_a, fma_a, fmf_a);
    end
    @(negedge clock);
    rst_n = 1'b1;
    repeat (2) @(negedge clock);
    tests_run++;
    if (busy_a !== 1'b0 || done_a !== 1'b0 || omar_a !== 13'd0) begin
      tests_failed++;
      $display("FAIL rmid_idle: got busy=%b done=%b omar=%0d, expected 0 0 0", busy_a, done_a, omar_a);
    end
    fill_a_equal();
    gm_a[12] = om_a[12] + 16'd1;
    start_a = 1'b1;
    @(negedge clock);
    start_a = 1'b0;
    repeat (17) @(negedge clock);
    tests_run++;
    if (done_a !== 1'b1 || cnt_a !== 14'd1 || fma_a !== 13'd12 || fmf_a !== 1'b1 || pass_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL rmid_second: got done=%b cnt=%0d fma=%0d fmf=%b pass=%b, expected 1 1 12 1 0",
               done_a, cnt_a, fma_a, fmf_a, pass_a);
    end
  endtask

  task automatic test_restart_ignored();
    fill_a_equal();
    start_a = 1'b1;
    @(negedge clock);
    start_a = 1'b0;
    for (int k = 2; k <= 19; k++) begin
      @(negedge clock);
      if (k == 17) begin
        tests_run++;
        if (done_a !== 1'b0) begin
          tests_failed++;
          $display("FAIL restart_early: got done=%b at cycle 17, expected 0", done_a);
        end
      end
      if (k == 18) begin
        tests_run++;
        if (done_a !== 1'b1 || pass_a !== 1'b1 || cnt_a !== 14'd0) begin
          tests_failed++;
          $display("FAIL restart_done: got done=%b pass=%b cnt=%0d at cycle 18, expected 1 1 0", done_a, pass_a, cnt_a);
        end
      end
      if (k == 19) begin
        tests_run++;
        if (done_a !== 1'b1 || busy_a !== 1'b0) begin
          tests_failed++;
          $display("FAIL restart_finish: got done=%b busy=%b, expected 1 0", done_a, busy_a);
        end
      end
      start_a = (k == 5) || (k == 17);
    end
    start_a = 1'b0;
  endtask

  task automatic test_single();
    om_c = 16'h1234; gm_c = 16'h1234;
    start_c = 1'b1;
    @(negedge clock);
    start_c = 1'b0;
    tests_run++;
    if (busy_c !== 1'b1 || done_c !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_busy: got busy=%b done=%b, expected 1 0", busy_c, done_c);
    end
    @(negedge clock);
    tests_run++;
    if (done_c !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_early: got done=%b at cycle 2, expected 0", done_c);
    end
    @(negedge clock);
    tests_run++;
    if (done_c !== 1'b1 || pass_c !== 1'b1 || busy_c !== 1'b0 || omar_c !== 13'd0) begin
      tests_failed++;
      $display("FAIL single_pass: got done=%b pass=%b busy=%b omar=%0d, expected 1 1 0 0", done_c, pass_c, busy_c, omar_c);
    end
    gm_c = 16'h1235;
    start_c = 1'b1;
    @(negedge clock);
    start_c = 1'b0;
    repeat (2) @(negedge clock);
    tests_run++;
    if (done_c !== 1'b1 || cnt_c !== 14'd1 || fmf_c !== 1'b1 || fma_c !== 13'd0 || pass_c !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_fail: got done=%b cnt=%0d fmf=%b fma=%0d pass=%b, expected 1 1 1 0 0",
               done_c, cnt_c, fmf_c, fma_c, pass_c);
    end
  endtask

  initial begin
    om_c = 16'h0; gm_c = 16'h0;
    fill_a_equal();
    for (int i = 0; i < 8; i++) begin
      om_b[i] = 16'h0;
      gm_b[i] = 16'h0;
    end
    test_reset();
    test_identical();
    test_two_mismatches();
    test_flag();
    test_saturate();
    test_reset_mid();
    test_restart_ignored();
    test_single();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
